// File: rtl/fft_row_ctrl.sv
// rtl/fft_row_ctrl.sv - row sequencer feeding one image row at a time through an FFT256 core
// Reads a row from line memory, streams it into the FFT, writes the bins back, one row in flight.
module fft_row_ctrl #(
  parameter int FFT_SIZE  = 256,
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8:0]           num_rows,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 src_rd_en,
  output logic [15:0]          src_addr,
  input  logic [IN_WIDTH-1:0]  src_data_r,
  input  logic [IN_WIDTH-1:0]  src_data_i,
  output logic                 fft_in_valid,
  output logic [IN_WIDTH-1:0]  fft_din_r,
  output logic [IN_WIDTH-1:0]  fft_din_i,
  input  logic                 fft_out_valid,
  input  logic [OUT_WIDTH-1:0] fft_dout_r,
  input  logic [OUT_WIDTH-1:0] fft_dout_i,
  output logic                 snk_wr_en,
  output logic [15:0]          snk_addr,
  output logic [OUT_WIDTH-1:0] snk_data_r,
  output logic [OUT_WIDTH-1:0] snk_data_i
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    COL_LAST = 8'(FFT_SIZE - 1);
  localparam logic [8:0]    BIN_FULL = 9'(FFT_SIZE);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [8:0] row_q, row_d, nrows_q, nrows_d, bin_q, bin_d;
  logic [7:0] col_q, col_d;
  logic flush_q, flush_d;
  logic [IW-1:0] idle_q, idle_d;
  logic err_q, err_d;
  logic rd1_q, rd1_d, fin_v_q, fin_v_d;
  logic [IN_WIDTH-1:0] din_r_q, din_r_d, din_i_q, din_i_d;
  logic wr_q, wr_d;
  logic [15:0] waddr_q, waddr_d;
  logic [OUT_WIDTH-1:0] wdat_r_q, wdat_r_d, wdat_i_q, wdat_i_d;
  logic in_flight, accept;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    nrows_d  = nrows_q;
    bin_d    = bin_q;
    col_d    = col_q;
    flush_d  = flush_q;
    idle_d   = '0;
    err_d    = err_q;
    din_r_d  = din_r_q;
    din_i_d  = din_i_q;
    waddr_d  = waddr_q;
    wdat_r_d = wdat_r_q;
    wdat_i_d = wdat_i_q;

    in_flight = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_DRAIN);
    accept    = fft_out_valid && in_flight && (bin_q != BIN_FULL);

    // Two-stage read pipeline: memory latency plus the input register.
    rd1_d   = (state_q == S_LOAD);
    fin_v_d = rd1_q;
    if (rd1_q) begin
      din_r_d = src_data_r;
      din_i_d = src_data_i;
    end

    wr_d = accept;
    if (accept) begin
      waddr_d  = {row_q[7:0], bin_q[7:0]};
      wdat_r_d = fft_dout_r;
      wdat_i_d = fft_dout_i;
      bin_d    = bin_q + 9'd1;
    end
    if (fft_out_valid && !accept) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && (num_rows != 9'd0)) begin
          state_d = S_LOAD;
          nrows_d = num_rows;
          row_d   = '0;
          col_d   = '0;
          bin_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        col_d = col_q + 8'd1;
        if (col_q == COL_LAST) begin
          col_d   = '0;
          flush_d = 1'b0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) begin
          flush_d = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bin_q == BIN_FULL) begin
          if (row_q == nrows_q - 9'd1) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 9'd1;
            bin_d   = '0;
            col_d   = '0;
            state_d = S_LOAD;
          end
        end else if (!accept) begin
          idle_d = idle_q + IW'(1);
          if (idle_d == IDLE_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      nrows_q  <= '0;
      bin_q    <= '0;
      col_q    <= '0;
      flush_q  <= 1'b0;
      idle_q   <= '0;
      err_q    <= 1'b0;
      rd1_q    <= 1'b0;
      fin_v_q  <= 1'b0;
      din_r_q  <= '0;
      din_i_q  <= '0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdat_r_q <= '0;
      wdat_i_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      nrows_q  <= nrows_d;
      bin_q    <= bin_d;
      col_q    <= col_d;
      flush_q  <= flush_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      rd1_q    <= rd1_d;
      fin_v_q  <= fin_v_d;
      din_r_q  <= din_r_d;
      din_i_q  <= din_i_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdat_r_q <= wdat_r_d;
      wdat_i_q <= wdat_i_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err          = err_q;
  assign src_rd_en    = (state_q == S_LOAD);
  assign src_addr     = src_rd_en ? {row_q[7:0], col_q} : 16'h0000;
  assign fft_in_valid = fin_v_q;
  assign fft_din_r    = din_r_q;
  assign fft_din_i    = din_i_q;
  assign snk_wr_en    = wr_q;
  assign snk_addr     = waddr_q;
  assign snk_data_r   = wdat_r_q;
  assign snk_data_i   = wdat_i_q;

endmodule

// File: tb/tb_fft_row_ctrl.sv
// tb/tb_fft_row_ctrl.sv - self-checking bench for fft_row_ctrl with line-memory and FFT models
// Scenario table plus hand sequences for spurious output, num_rows=0 and mid-row reset.
module tb_fft_row_ctrl;
  localparam int IW = 12;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [8:0] num_rows = '0;
  logic busy, done, err, src_rd_en, fft_in_valid, snk_wr_en;
  logic [15:0] src_addr, snk_addr;
  logic [IW-1:0] src_data_r = '0, src_data_i = '0, fft_din_r, fft_din_i;
  logic fft_out_valid = 1'b0;
  logic [OW-1:0] fft_dout_r = '0, fft_dout_i = '0, snk_data_r, snk_data_i;

  always #5 clk = ~clk;

  fft_row_ctrl #(.FFT_SIZE(256), .IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .err(err),
    .src_rd_en(src_rd_en), .src_addr(src_addr),
    .src_data_r(src_data_r), .src_data_i(src_data_i),
    .fft_in_valid(fft_in_valid), .fft_din_r(fft_din_r), .fft_din_i(fft_din_i),
    .fft_out_valid(fft_out_valid), .fft_dout_r(fft_dout_r), .fft_dout_i(fft_dout_i),
    .snk_wr_en(snk_wr_en), .snk_addr(snk_addr),
    .snk_data_r(snk_data_r), .snk_data_i(snk_data_i)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int          nrows;
    int          gap;
    int          drop;
    bit          busy_start;
    int          exp_wr;
    logic [15:0] exp_last;
    int          exp_done;
    bit          exp_err;
  } vec_t;
  vec_t tbl[5];

  int lat = 300, gap = 0, drop = 256;
  logic mdl_clr = 1'b0, spur_req = 1'b0;
  int wr_total = 0, rd_total = 0, done_total = 0, wr_base = 0;
  logic [15:0] last_addr = '0;

  function automatic logic [11:0] mem_r(input logic [15:0] a);
    return {a[3:0], a[15:8]} ^ 12'h5A5;
  endfunction
  function automatic logic [11:0] mem_i(input logic [15:0] a);
    return a[11:0] + 12'd7;
  endfunction
  function automatic logic [31:0] fft_val(input int row, input int bin);
    logic [7:0] r8, b8;
    r8 = row[7:0];
    b8 = bin[7:0];
    return {({r8, b8} ^ 16'hC3A5), 16'(bin * 3 + row)};
  endfunction

  // Line memory, FFT model and output monitors share one process so the queue has one owner.
  logic h0_en = 0, h1_en = 0, m_en, nxt_v;
  logic [15:0] h0_a = 0, h1_a = 0, m_a;
  logic [31:0] nxt_d;
  int rd_seq = 0, in_cnt = 0, in_row = 0, in_start = 0, pend = 0, pend_row = 0;
  int pend_start = 0, out_bin = 0, cyc = 0;
  wr_t e;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      m_en = src_rd_en;
      m_a = src_addr;
      nxt_v = 1'b0;
      nxt_d = '0;
      if (!rst_n || mdl_clr) begin
        h0_en = 0; h1_en = 0; m_en = 0;
        rd_seq = 0; in_cnt = 0; in_row = 0; pend = 0; out_bin = 0;
        exp_q.delete();
      end else begin
        if (done) done_total++;
        if (fft_in_valid || h1_en) begin
          chk("fft_in_valid", fft_in_valid, h1_en);
          if (h1_en) chk("fft_din", {fft_din_r, fft_din_i}, {mem_r(h1_a), mem_i(h1_a)});
        end
        if (snk_wr_en) begin
          if (exp_q.size() == 0) chk("snk_wr_en_unexpected", snk_wr_en, 1'b0);
          else begin
            e = exp_q.pop_front();
            chk("snk_addr", snk_addr, e.addr);
            chk("snk_data", {snk_data_r, snk_data_i}, e.data);
          end
          wr_total++;
          last_addr = snk_addr;
        end
        if (src_rd_en) begin
          chk("src_addr", src_addr, rd_seq[15:0]);
          if (src_addr[7:0] == 8'd0)
            chk("row_start_after_drain", wr_total - wr_base, int'(src_addr[15:8]) * 256);
          rd_seq++;
          rd_total++;
        end
        if (fft_in_valid) begin
          if (in_cnt == 0) in_start = cyc;
          in_cnt++;
          if (in_cnt == 256) begin
            pend = 1; pend_row = in_row; pend_start = in_start;
            out_bin = 0; in_cnt = 0; in_row++;
          end
        end
        if (spur_req) begin
          nxt_v = 1'b1;
          nxt_d = 32'hDEADBEEF;
        end else if (pend != 0 && cyc >= pend_start + lat && out_bin < drop &&
                     (gap == 0 || $urandom_range(0, 3) != 0)) begin
          nxt_v = 1'b1;
          nxt_d = fft_val(pend_row, out_bin);
          e.addr = {pend_row[7:0], out_bin[7:0]};
          e.data = nxt_d;
          exp_q.push_back(e);
          out_bin++;
          if (out_bin == 256) pend = 0;
        end
      end
      h1_en = h0_en; h1_a = h0_a;
      h0_en = m_en;  h0_a = m_a;
      @(posedge clk);
      #1;
      if (m_en) begin
        src_data_r = mem_r(m_a);
        src_data_i = mem_i(m_a);
      end
      #1;
      fft_out_valid = nxt_v;
      {fft_dout_r, fft_dout_i} = nxt_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_model();
    mdl_clr = 1'b1;
    tick();
    mdl_clr = 1'b0;
  endtask

  task automatic run_case(input int i);
    int n, d0;
    lat = 300; gap = tbl[i].gap; drop = tbl[i].drop;
    clr_model();
    wr_base = wr_total;
    d0 = done_total;
    num_rows = 9'(tbl[i].nrows);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("busy_after_start[%0d]", i), busy, 1'b1);
    chk($sformatf("err_cleared_by_start[%0d]", i), err, 1'b0);
    if (tbl[i].busy_start) begin
      repeat (50) tick();
      num_rows = 9'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("row_after_busy_start", src_addr[15:8], 8'd0);
      chk("busy_after_busy_start", busy, 1'b1);
    end
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("busy_timeout[%0d]", i), busy, 1'b0);
    chk($sformatf("done_count[%0d]", i), done_total - d0, tbl[i].exp_done);
    chk($sformatf("err_end[%0d]", i), err, tbl[i].exp_err);
    chk($sformatf("write_count[%0d]", i), wr_total - wr_base, tbl[i].exp_wr);
    chk($sformatf("last_addr[%0d]", i), last_addr, tbl[i].exp_last);
    chk($sformatf("queue_drained[%0d]", i), exp_q.size(), 0);
  endtask

  initial begin
    int n, r0, w0, d0;
    tbl[0] = '{1, 0, 256, 1'b0, 256, 16'h00FF, 1, 1'b0};
    tbl[1] = '{3, 1, 256, 1'b0, 768, 16'h02FF, 1, 1'b0};
    tbl[2] = '{1, 0, 256, 1'b1, 256, 16'h00FF, 1, 1'b0};
    tbl[3] = '{2, 1, 256, 1'b0, 512, 16'h01FF, 1, 1'b0};
    tbl[4] = '{1, 0, 100, 1'b0, 100, 16'h0063, 0, 1'b1};

    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_ctrl", {busy, done, err, src_rd_en, fft_in_valid, snk_wr_en, src_addr, snk_addr}, '0);
    chk("reset_data", {fft_din_r, fft_din_i, snk_data_r, snk_data_i}, '0);
    tick();
    rst_n = 1'b1;
    tick();

    w0 = wr_total;
    spur_req = 1'b1;
    tick();
    spur_req = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("err_after_spurious", err, 1'b1);
    chk("no_write_on_spurious", wr_total - w0, 0);

    num_rows = 9'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("busy_num_rows0", busy, 1'b0);
    chk("err_kept_num_rows0", err, 1'b1);
    chk("no_read_num_rows0", rd_total, 0);

    for (int i = 0; i < 5; i++) run_case(i);

    lat = 300; gap = 0; drop = 256;
    clr_model();
    wr_base = wr_total;
    num_rows = 9'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(src_rd_en && src_addr[7:0] == 8'd127) && n < 5000);
    chk("reached_col127", n < 5000, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_ctrl", {busy, done, err, src_rd_en, fft_in_valid, snk_wr_en, src_addr, snk_addr}, '0);
    chk("midreset_data", {fft_din_r, fft_din_i, snk_data_r, snk_data_i}, '0);
    r0 = rd_total; w0 = wr_total; d0 = done_total;
    repeat (400) tick();
    @(negedge clk);
    chk("no_reads_after_reset", rd_total - r0, 0);
    chk("no_writes_after_reset", wr_total - w0, 0);
    chk("no_done_after_reset", done_total - d0, 0);
    chk("idle_after_reset", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_row_ctrl.md
FFT_ROW_CTRL -- requirements
Module: fft_row_ctrl

Interface
REQ-001 Parameter FFT_SIZE, 256, points per frame (one image row).
REQ-002 Parameter IN_WIDTH, 12, FFT input sample width (signed).
REQ-003 Parameter OUT_WIDTH, 16, FFT output sample width (signed).
REQ-004 Parameter TIMEOUT, 1024, max idle cycles in DRAIN before abort.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle request to process num_rows rows.
REQ-008 num_rows  in  9  row count, 1..256, sampled on accepted start.
REQ-009 busy  out  1  high from accepted start until DONE state exit.
REQ-010 done  out  1  one-cycle pulse, all rows written.
REQ-011 err  out  1  sticky error flag, cleared only by an accepted start or reset.
REQ-012 src_rd_en  out  1  line-memory read strobe.
REQ-013 src_addr  out  16  {row[7:0], col[7:0]} read address.
REQ-014 src_data_r / src_data_i  in  IN_WIDTH each  read data, valid one cycle after src_rd_en.
REQ-015 fft_in_valid  out  1; fft_din_r / fft_din_i  out  IN_WIDTH each  to FFT256.
REQ-016 fft_out_valid  in  1; fft_dout_r / fft_dout_i  in  OUT_WIDTH each  from FFT256.
REQ-017 snk_wr_en  out  1; snk_addr  out  16 {row, bin}; snk_data_r / snk_data_i  out  OUT_WIDTH each  result write port.

Function
REQ-018 The block SHALL implement states IDLE, LOAD, FLUSH, DRAIN, DONE.
REQ-019 IDLE->LOAD on start; start SHALL be ignored in any other state; num_rows=0 SHALL be ignored (stay IDLE, err unchanged).
REQ-020 LOAD SHALL assert src_rd_en for exactly FFT_SIZE contiguous cycles, col 0..255, row = current row.
REQ-021 fft_in_valid for column c SHALL assert exactly 2 cycles after src_rd_en for c, with fft_din = registered src_data; FFT_SIZE contiguous valid cycles per row, no gaps.
REQ-022 LOAD->FLUSH after col 255 issued; FLUSH lasts 2 cycles (pipeline empties), then ->DRAIN.
REQ-023 fft_out_valid SHALL be accepted in LOAD, FLUSH and DRAIN; each accepted cycle increments a 9-bit bin counter (0..256).
REQ-024 snk_wr_en SHALL assert 1 cycle after each accepted fft_out_valid, snk_addr = {row, bin}, snk_data = registered fft_dout.
REQ-025 DRAIN exit when bin counter = 256: if row = num_rows-1 ->DONE, else row+1, bin counter cleared, ->LOAD.
REQ-026 fft_out_valid in IDLE/DONE, or when bin counter already 256, SHALL set err and produce no write.
REQ-027 A DRAIN idle counter SHALL reset on every accepted fft_out_valid; reaching TIMEOUT SHALL set err and force ->IDLE without done.
REQ-028 DONE SHALL last 1 cycle with done=1, then ->IDLE; busy deasserts in the cycle after DONE.
REQ-029 Only one row SHALL be in flight; next row LOAD never starts before all 256 outputs of the current row are written.

Reset
REQ-030 On rst_n=0 at a clock edge: state IDLE, row/col/bin/idle counters 0, busy=0, done=0, err=0, src_rd_en=0, fft_in_valid=0, snk_wr_en=0, all data/address outputs 0.
REQ-031 Reset mid-operation SHALL abort immediately; no further src_rd_en, fft_in_valid or snk_wr_en until a new start.

Verification
REQ-032 start, num_rows=1, FFT model latency 300 -> 256 src reads row 0, 256 contiguous fft_in_valid 2 cycles later, 256 writes addr 0x0000..0x00FF, one done pulse, err=0.
REQ-033 num_rows=3, FFT out_valid with random gaps -> rows 0..2 written in order, each LOAD begins only after prior bin 256, addr 0x02FF last, done once.
REQ-034 start while busy and start with num_rows=0 -> both ignored, busy/row state unchanged.
REQ-035 spurious fft_out_valid in IDLE -> err=1, snk_wr_en stays 0; next accepted start clears err.
REQ-036 FFT model drops output after 100 bins -> after TIMEOUT=1024 idle cycles err=1, IDLE, no done.
REQ-037 rst_n=0 for 1 cycle during LOAD col 128 -> all outputs 0 next cycle, no reads/writes until new start.
